lcd_line_writer: RTL and testbench

Consumes two 16-character ASCII line buffers, each 128 bits with char 0 at bits [127:120]. Drives an HD44780-compatible character LCD over its 8-bit parallel bus, write-only.
Runs the LCD power-up/init sequence once after reset, then repeatedly refreshes both display lines. Sits between the text generators (name/status ASCII blocks) and the board LCD pins.

---
 rtl/lcd_pkg.sv | 49 ++++
 rtl/lcd_bus_xfer.sv | 106 ++++++++++
 rtl/lcd_line_writer.sv | 183 ++++++++++++++++++
 tb/tb_lcd_line_writer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 line writer: command bytes, state
// encodings and small helpers used by the sequencer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } main_state_t;

  typedef enum logic [2:0] {
    XF_IDLE,
    XF_SETUP,
    XF_PULSE,
    XF_HOLD,
    XF_WAIT
  } xfer_phase_t;

  // Init command list, indexed in the order the controller must receive it.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Character idx of a 16-char line; char 0 sits in the top byte.
  function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] idx);
    logic [127:0] sh;
    sh = line << {idx, 3'b000};
    return sh[127:120];
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One write transfer on the LCD parallel bus: SETUP, PULSE (lcd_e high),
// HOLD, then a settle WAIT. rs/data are latched at start and held until the
// next start, so they stay stable across the whole transfer.
// Handshake: start is accepted only while idle or in the last WAIT cycle
// (the cycle where done=1); a start in that cycle chains the next transfer
// with no gap. done is a single-cycle pulse in the last WAIT cycle.
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int E_CYC    = 25,
  parameter int WAIT_CYC = 2500,
  parameter int CLR_CYC  = 100000,
  parameter int CNT_W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam logic [CNT_W-1:0] E_LAST = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLR_CYC - 1);

  xfer_phase_t      phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             long_q;
  logic             load;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? C_LAST : W_LAST;

  // Phase sequencing and start acceptance.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    load    = 1'b0;
    case (phase_q)
      XF_IDLE: begin
        if (start) begin
          load    = 1'b1;
          phase_d = XF_SETUP;
        end
      end
      XF_SETUP: begin
        phase_d = XF_PULSE;
        cnt_d   = '0;
      end
      XF_PULSE: begin
        if (cnt_q == E_LAST) phase_d = XF_HOLD;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      XF_HOLD: begin
        phase_d = XF_WAIT;
        cnt_d   = '0;
      end
      XF_WAIT: begin
        if (cnt_q == wait_last) begin
          done = 1'b1;
          if (start) begin
            load    = 1'b1;
            phase_d = XF_SETUP;
          end else begin
            phase_d = XF_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: phase_d = XF_IDLE;
    endcase
  end

  // Phase/counter registers and the latched bus values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= XF_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (load) begin
        rs_q   <= rs;
        data_q <= data;
        long_q <= long_wait;
      end
    end
  end

  assign lcd_e    = (phase_q == XF_PULSE);
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_line_writer.sv
// Sequencer for a 2x16 HD44780 display: power-up delay, init commands, then
// frame refreshes (line-1 address, 16 chars, line-2 address, 16 chars).
// Each line's text is snapshotted when its address command starts so a
// refresh never mixes old and new text.
module lcd_line_writer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750000,
  parameter int E_CYC     = 25,
  parameter int WAIT_CYC  = 2500,
  parameter int CLR_CYC   = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] line1_ascii,
  input  logic [127:0] line2_ascii,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int MAX_CYC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC);

  main_state_t      state_q, state_d;
  logic [CNT_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [1:0]       init_idx_q, init_idx_d;
  logic [3:0]       char_idx_q, char_idx_d;
  logic [127:0]     shadow1_q, shadow2_q;
  logic             snap1, snap2;
  logic             init_done_q, init_done_d;
  logic             frame_done_q, frame_done_d;

  logic             x_start, x_rs, x_long, x_done;
  logic [7:0]       x_data;

  // Only the clear command needs the long settle time.
  assign x_long = !x_rs && (x_data == CMD_CLEAR);

  // Main sequencing: each state issues the next transfer when the previous one ends.
  always_comb begin
    state_d      = state_q;
    pw_cnt_d     = pw_cnt_q;
    init_idx_d   = init_idx_q;
    char_idx_d   = char_idx_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    x_start      = 1'b0;
    x_rs         = 1'b0;
    x_data       = 8'h00;
    snap1        = 1'b0;
    snap2        = 1'b0;
    case (state_q)
      ST_PWRUP: begin
        if (pw_cnt_q == PWRUP_LAST) begin
          x_start    = 1'b1;
          x_data     = CMD_FUNC_SET;
          init_idx_d = 2'd0;
          state_d    = ST_INIT;
        end else begin
          pw_cnt_d = pw_cnt_q + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (x_done) begin
          if (init_idx_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            x_start    = 1'b1;
            x_data     = init_cmd(init_idx_q + 2'd1);
            init_idx_d = init_idx_q + 2'd1;
          end
        end
      end
      ST_IDLE: begin
        if (enable) begin
          x_start = 1'b1;
          x_data  = CMD_LINE1;
          snap1   = 1'b1;
          state_d = ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        if (x_done) begin
          x_start    = 1'b1;
          x_rs       = 1'b1;
          x_data     = char_at(shadow1_q, 4'd0);
          char_idx_d = 4'd0;
          state_d    = ST_LINE1;
        end
      end
      ST_LINE1: begin
        if (x_done) begin
          x_start = 1'b1;
          if (char_idx_q == 4'd15) begin
            x_data  = CMD_LINE2;
            snap2   = 1'b1;
            state_d = ST_ADDR2;
          end else begin
            x_rs       = 1'b1;
            x_data     = char_at(shadow1_q, char_idx_q + 4'd1);
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      ST_ADDR2: begin
        if (x_done) begin
          x_start    = 1'b1;
          x_rs       = 1'b1;
          x_data     = char_at(shadow2_q, 4'd0);
          char_idx_d = 4'd0;
          state_d    = ST_LINE2;
        end
      end
      ST_LINE2: begin
        if (x_done) begin
          if (char_idx_q == 4'd15) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            x_start    = 1'b1;
            x_rs       = 1'b1;
            x_data     = char_at(shadow2_q, char_idx_q + 4'd1);
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  // Sequencer registers, line snapshots and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PWRUP;
      pw_cnt_q     <= '0;
      init_idx_q   <= 2'd0;
      char_idx_q   <= 4'd0;
      shadow1_q    <= '0;
      shadow2_q    <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pw_cnt_q     <= pw_cnt_d;
      init_idx_q   <= init_idx_d;
      char_idx_q   <= char_idx_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      if (snap1) shadow1_q <= line1_ascii;
      if (snap2) shadow2_q <= line2_ascii;
    end
  end

  lcd_bus_xfer #(
    .E_CYC    (E_CYC),
    .WAIT_CYC (WAIT_CYC),
    .CLR_CYC  (CLR_CYC),
    .CNT_W    (CNT_W)
  ) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .start     (x_start),
    .rs        (x_rs),
    .data      (x_data),
    .long_wait (x_long),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (x_done)
  );

  assign lcd_rw     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Directed bench for lcd_line_writer with short timing overrides
// (normal transfer 7 cycles, clear 14 cycles).
module tb_lcd_line_writer;

  localparam int PWRUP_CYC = 5;
  localparam int E_CYC     = 2;
  localparam int WAIT_CYC  = 3;
  localparam int CLR_CYC   = 10;

  localparam logic [127:0] L_NOPO    = {"Nopo", {12{8'h20}}};
  localparam logic [127:0] L_BUSAN   = {"Busan", {11{8'h20}}};
  localparam logic [127:0] L_DONGNAE = {"Dongnae", {9{8'h20}}};

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [127:0] line1_ascii = '0;
  logic [127:0] line2_ascii = '0;
  logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  lcd_line_writer #(
    .PWRUP_CYC (PWRUP_CYC),
    .E_CYC     (E_CYC),
    .WAIT_CYC  (WAIT_CYC),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .line1_ascii (line1_ascii),
    .line2_ascii (line2_ascii),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data    (lcd_data),
    .init_done   (init_done),
    .frame_done  (frame_done)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         rise_q[$];
  int         fd_q[$];
  int         init_rise = -1;

  // ---------------- bus monitor (negedge sampling) ----------------
  logic       m_prev_e = 1'b0, m_prev_rs = 1'b0, m_prev_init = 1'b0;
  logic [7:0] m_prev_data = 8'h00;
  logic       m_ref_rs = 1'b0;
  logic [7:0] m_ref_data = 8'h00;
  bit         m_in = 1'b0;
  int         m_len = 0;

  always @(negedge clk) begin
    n_checks = n_checks + 1;
    if (lcd_rw !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL rw_low: lcd_rw=%b expected 0 (cycle %0d)", lcd_rw, cyc);
    end
    if (rst) begin
      m_in  = 1'b0;
      m_len = 0;
    end else begin
      if (lcd_e === 1'b1 && m_prev_e !== 1'b1) begin
        cap_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back(cyc);
        m_ref_rs   = m_prev_rs;
        m_ref_data = m_prev_data;
        m_in       = 1'b1;
        m_len      = 1;
        n_checks   = n_checks + 1;
        if ({lcd_rs, lcd_data} !== {m_ref_rs, m_ref_data}) begin
          n_err = n_err + 1;
          $display("FAIL setup_stable: got %h expected %h (cycle %0d)", {lcd_rs, lcd_data}, {m_ref_rs, m_ref_data}, cyc);
        end
      end else if (lcd_e === 1'b1 && m_in) begin
        m_len    = m_len + 1;
        n_checks = n_checks + 1;
        if ({lcd_rs, lcd_data} !== {m_ref_rs, m_ref_data}) begin
          n_err = n_err + 1;
          $display("FAIL pulse_stable: got %h expected %h (cycle %0d)", {lcd_rs, lcd_data}, {m_ref_rs, m_ref_data}, cyc);
        end
      end else if (lcd_e === 1'b0 && m_prev_e === 1'b1 && m_in) begin
        n_checks = n_checks + 2;
        if (m_len != E_CYC) begin
          n_err = n_err + 1;
          $display("FAIL e_width: lcd_e high %0d cycles expected %0d (cycle %0d)", m_len, E_CYC, cyc);
        end
        if ({lcd_rs, lcd_data} !== {m_ref_rs, m_ref_data}) begin
          n_err = n_err + 1;
          $display("FAIL hold_stable: got %h expected %h (cycle %0d)", {lcd_rs, lcd_data}, {m_ref_rs, m_ref_data}, cyc);
        end
        m_in = 1'b0;
      end
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (init_done === 1'b1 && m_prev_init !== 1'b1) init_rise = cyc;
    end
    m_prev_e    = lcd_e;
    m_prev_rs   = lcd_rs;
    m_prev_data = lcd_data;
    m_prev_init = init_done;
  end

  // ---------------- driver / wait tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_caps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (fd_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (init_rise >= 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[127-8*i -: 8]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[127-8*i -: 8]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit ok;
    int x;
    rst = 1'b1;
    enable = 1'b0;
    tick(3);
    n_checks = n_checks + 1;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done} !== 13'h0) begin
      n_err = n_err + 1;
      $display("FAIL reset_outputs: e=%b rs=%b rw=%b data=%h init=%b frame=%b expected all 0",
               lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done);
    end
    cap_q.delete();
    rise_q.delete();
    exp_q.delete();
    init_rise = -1;
    x = cyc;
    rst = 1'b0;
    wait_init(100, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL init_timeout: init_done=%b expected 1 within 100 cycles", init_done);
    end
    n_checks = n_checks + 1;
    if (rise_q.size() == 0 || rise_q[0] - x != 7) begin
      n_err = n_err + 1;
      $display("FAIL first_e_rise: first lcd_e high in cycle %0d expected 7", (rise_q.size() == 0) ? -1 : rise_q[0] - x);
    end
    n_checks = n_checks + 1;
    if (init_rise - x != 41) begin
      n_err = n_err + 1;
      $display("FAIL init_done_cycle: rose in cycle %0d expected 41", init_rise - x);
    end
    push_init();
    n_checks = n_checks + 1;
    if (cap_q.size() != exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL init_count: %0d transfers expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks = n_checks + 1;
      if (cap_q[i] !== exp_q[i]) begin
        n_err = n_err + 1;
        $display("FAIL init_byte[%0d]: got rs/data %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    tick(20);
    n_checks = n_checks + 1;
    if (cap_q.size() != 4 || init_done !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL init_quiet: %0d transfers init_done=%b expected 4 and 1", cap_q.size(), init_done);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int x;
    line1_ascii = L_NOPO;
    line2_ascii = L_DONGNAE;
    cap_q.delete();
    rise_q.delete();
    fd_q.delete();
    exp_q.delete();
    x = cyc;
    enable = 1'b1;
    wait_caps(1, 20, ok);
    enable = 1'b0;
    wait_fd(1, 400, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL frame_timeout: frame_done count %0d expected 1", fd_q.size());
    end
    n_checks = n_checks + 1;
    if (rise_q.size() == 0 || rise_q[0] - x != 2) begin
      n_err = n_err + 1;
      $display("FAIL addr1_start: first rise offset %0d expected 2", (rise_q.size() == 0) ? -1 : rise_q[0] - x);
    end
    n_checks = n_checks + 1;
    if (fd_q.size() == 0 || fd_q[0] - x != 239) begin
      n_err = n_err + 1;
      $display("FAIL frame_done_cycle: offset %0d expected 239 (238 after ADDR1 SETUP)", (fd_q.size() == 0) ? -1 : fd_q[0] - x);
    end
    push_frame(L_NOPO, L_DONGNAE);
    n_checks = n_checks + 1;
    if (cap_q.size() != exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL frame_count: %0d transfers expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks = n_checks + 1;
      if (cap_q[i] !== exp_q[i]) begin
        n_err = n_err + 1;
        $display("FAIL frame_byte[%0d]: got rs/data %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    tick(30);
    n_checks = n_checks + 1;
    if (cap_q.size() != 34 || fd_q.size() != 1) begin
      n_err = n_err + 1;
      $display("FAIL frame_stop: %0d transfers %0d frame_done expected 34 and 1", cap_q.size(), fd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    line1_ascii = L_NOPO;
    line2_ascii = L_DONGNAE;
    cap_q.delete();
    fd_q.delete();
    exp_q.delete();
    enable = 1'b1;
    wait_caps(3, 30, ok);
    line1_ascii = L_BUSAN;
    wait_caps(35, 400, ok);
    enable = 1'b0;
    wait_fd(2, 400, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL b2b_timeout: frame_done count %0d expected 2", fd_q.size());
    end
    push_frame(L_NOPO, L_DONGNAE);
    push_frame(L_BUSAN, L_DONGNAE);
    n_checks = n_checks + 1;
    if (cap_q.size() != exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL b2b_count: %0d transfers expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks = n_checks + 1;
      if (cap_q[i] !== exp_q[i]) begin
        n_err = n_err + 1;
        $display("FAIL b2b_byte[%0d]: got rs/data %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    line1_ascii = L_NOPO;
    line2_ascii = L_DONGNAE;
    cap_q.delete();
    fd_q.delete();
    exp_q.delete();
    enable = 1'b1;
    wait_caps(7, 80, ok);
    enable = 1'b0;
    wait_fd(1, 400, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL drop_timeout: frame_done count %0d expected 1", fd_q.size());
    end
    push_frame(L_NOPO, L_DONGNAE);
    n_checks = n_checks + 1;
    if (cap_q.size() != exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL drop_count: %0d transfers expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks = n_checks + 1;
      if (cap_q[i] !== exp_q[i]) begin
        n_err = n_err + 1;
        $display("FAIL drop_byte[%0d]: got rs/data %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
    tick(30);
    n_checks = n_checks + 1;
    if (cap_q.size() != 34 || fd_q.size() != 1) begin
      n_err = n_err + 1;
      $display("FAIL drop_quiet: %0d transfers %0d frame_done expected 34 and 1", cap_q.size(), fd_q.size());
    end
    cap_q.delete();
    fd_q.delete();
    enable = 1'b1;
    wait_caps(1, 10, ok);
    enable = 1'b0;
    n_checks = n_checks + 1;
    if (!ok || cap_q[0] !== 9'h080) begin
      n_err = n_err + 1;
      $display("FAIL restart_addr1: got rs/data %h expected 080", (cap_q.size() == 0) ? 9'h1FF : cap_q[0]);
    end
    wait_fd(1, 400, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL restart_timeout: frame_done count %0d expected 1", fd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    cap_q.delete();
    exp_q.delete();
    enable = 1'b1;
    wait_caps(3, 40, ok);
    rst = 1'b1;
    tick(1);
    n_checks = n_checks + 1;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done} !== 13'h0) begin
      n_err = n_err + 1;
      $display("FAIL midreset_outputs: e=%b rs=%b rw=%b data=%h init=%b frame=%b expected all 0",
               lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done);
    end
    enable = 1'b0;
    tick(2);
    cap_q.delete();
    init_rise = -1;
    rst = 1'b0;
    wait_init(100, ok);
    n_checks = n_checks + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL reinit_timeout: init_done=%b expected 1", init_done);
    end
    push_init();
    n_checks = n_checks + 1;
    if (cap_q.size() != exp_q.size()) begin
      n_err = n_err + 1;
      $display("FAIL reinit_count: %0d transfers expected %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks = n_checks + 1;
      if (cap_q[i] !== exp_q[i]) begin
        n_err = n_err + 1;
        $display("FAIL reinit_byte[%0d]: got rs/data %h expected %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    tick(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
